// File: rtl/dsp_pkg.sv
// Shared DSP-chain definitions: serializer state encoding and default sizing.
//   DATA_W_DEF  : default sample width in bits
//   CLK_DIV_DEF : default sample_clock cycles per half bit-clock period
package dsp_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned CLK_DIV_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock divider: toggles bclk every CLK_DIV enabled cycles and flags the
// cycle in which a rising or falling toggle is committed.
//   sample_clock : clock
//   reset        : synchronous active-high reset
//   enable       : run the divider; when low the counter and bclk are held at 0
//   bclk         : registered bit clock
//   rise_c       : this cycle's edge takes bclk 0 -> 1
//   fall_c       : this cycle's edge takes bclk 1 -> 0
module bclk_divider
    import dsp_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic sample_clock,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] div_cnt;
    logic             wrap_c;

    assign wrap_c = enable && (div_cnt == CNT_W'(CLK_DIV - 1));
    assign rise_c = wrap_c && !bclk;
    assign fall_c = wrap_c && bclk;

    // Half-period counter and bit clock register
    always_ff @(posedge sample_clock) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap_c) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dac_serializer.sv
// Left-justified mono DAC serializer: takes one sample per frame through a
// single-entry holding register and sends it MSB first on both channels.
// Optional feature: define DAC_SERIALIZER_UNDERRUN_CNT_EN to add a saturating
// 16-bit underrun counter output.
//   sample_clock   : clock
//   reset          : synchronous active-high reset
//   input_sample   : two's-complement sample
//   in_valid       : input_sample valid
//   in_ready       : holding register empty (always 1 in IDLE)
//   dac_bclk       : serial bit clock
//   dac_lrclk      : channel select, 0 = left, 1 = right
//   dac_sdata      : serial data, changes on bclk falling events
//   underrun       : one-cycle pulse when a frame starts with no new sample
//   underrun_count : saturating underrun count (optional)
module dac_serializer
    import dsp_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic              sample_clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_sample,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dac_bclk,
    output logic              dac_lrclk,
    output logic              dac_sdata,
    output logic              underrun
`ifdef DAC_SERIALIZER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    localparam int unsigned IDX_W = $clog2(2 * DATA_W);

    state_t            state_q,      state_d;
    logic [DATA_W-1:0] shifter_q,    shifter_d;
    logic [DATA_W-1:0] prev_q,       prev_d;
    logic [DATA_W-1:0] hold_q,       hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [IDX_W-1:0]  bit_idx_q,    bit_idx_d;
    logic              lrclk_q,      lrclk_d;
    logic              underrun_q,   underrun_d;
    logic              in_ready_q,   in_ready_d;

    logic              accept_c;
    logic              bclk_fall_c;
    logic              bclk_rise_unused_c;

    bclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_divider (
        .sample_clock (sample_clock),
        .reset        (reset),
        .enable       (state_q == RUN),
        .bclk         (dac_bclk),
        .rise_c       (bclk_rise_unused_c),
        .fall_c       (bclk_fall_c)
    );

    assign accept_c  = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign dac_lrclk = lrclk_q;
    // The shifter MSB is the pin; it is cleared in IDLE so the pin idles low
    assign dac_sdata = shifter_q[DATA_W-1];
    assign underrun  = underrun_q;

    // State and datapath registers
    always_ff @(posedge sample_clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shifter_q    <= '0;
            prev_q       <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_idx_q    <= '0;
            lrclk_q      <= 1'b0;
            underrun_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            shifter_q    <= shifter_d;
            prev_q       <= prev_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_idx_q    <= bit_idx_d;
            lrclk_q      <= lrclk_d;
            underrun_q   <= underrun_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        shifter_d    = shifter_q;
        prev_d       = prev_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_idx_d    = bit_idx_q;
        lrclk_d      = lrclk_q;
        underrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // First sample goes straight to the shifter, bypassing the holding register
                if (accept_c) begin
                    state_d   = RUN;
                    shifter_d = input_sample;
                    prev_d    = input_sample;
                    bit_idx_d = '0;
                    lrclk_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept_c) begin
                    hold_d       = input_sample;
                    hold_valid_d = 1'b1;
                end
                if (bclk_fall_c) begin
                    if (bit_idx_q == IDX_W'(2 * DATA_W - 1)) begin
                        // Frame start: take the held sample or repeat the last one
                        bit_idx_d = '0;
                        lrclk_d   = 1'b0;
                        if (hold_valid_q) begin
                            shifter_d    = hold_q;
                            prev_d       = hold_q;
                            hold_valid_d = 1'b0;
                        end else begin
                            shifter_d  = prev_q;
                            underrun_d = 1'b1;
                        end
                    end else if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        // Left -> right: resend the same sample
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        lrclk_d   = 1'b1;
                        shifter_d = prev_q;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shifter_d = {shifter_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || !hold_valid_d;
    end

`ifdef DAC_SERIALIZER_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses
    always_ff @(posedge sample_clock) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (underrun_q && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_serializer.sv
// Directed self-checking bench for dac_serializer (CLK_DIV=4, DATA_W=16).
// Covers DAC_SERIALIZER_UNDERRUN_CNT_EN when that macro is defined.
module tb_dac_serializer;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAME_CYC = 4 * DATA_W * CLK_DIV;

    logic              sample_clock = 1'b0;
    logic              reset        = 1'b1;
    logic [DATA_W-1:0] input_sample = '0;
    logic              in_valid     = 1'b0;
    logic              in_ready;
    logic              dac_bclk;
    logic              dac_lrclk;
    logic              dac_sdata;
    logic              underrun;
`ifdef DAC_SERIALIZER_UNDERRUN_CNT_EN
    logic [15:0]       underrun_count;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int ur_count  = 0;
    int ur0       = 0;
    int lr_rise   = 0;
    int lr_period = 0;
    logic lr_prev = 1'b0;

    logic [31:0] frm;
    logic [31:0] lrv;

    dac_serializer #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) dut (
        .sample_clock (sample_clock),
        .reset        (reset),
        .input_sample (input_sample),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dac_bclk     (dac_bclk),
        .dac_lrclk    (dac_lrclk),
        .dac_sdata    (dac_sdata),
        .underrun     (underrun)
`ifdef DAC_SERIALIZER_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 sample_clock = ~sample_clock;

    always @(posedge sample_clock) cyc <= cyc + 1;

    // Count underrun pulse cycles and measure the lrclk period
    always @(negedge sample_clock) begin
        if (underrun === 1'b1) ur_count = ur_count + 1;
        if (dac_lrclk === 1'b1 && lr_prev === 1'b0) begin
            lr_period = cyc - lr_rise;
            lr_rise   = cyc;
        end
        lr_prev = dac_lrclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sample_clock);
        #1;
    endtask

    // Outputs packed as {bclk, lrclk, sdata, underrun, in_ready}
    function automatic logic [31:0] pins();
        return 32'({dac_bclk, dac_lrclk, dac_sdata, underrun, in_ready});
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        wait_cyc(2);
        check("reset_state", pins(), 32'b00001);
        reset = 1'b0;
    endtask

    // Leaves in_valid high; returns #1 after the accepting edge
    task automatic send(input logic [DATA_W-1:0] s);
        int   n;
        logic acc;
        n            = 0;
        acc          = 1'b0;
        input_sample = s;
        in_valid     = 1'b1;
        do begin
            acc = in_ready;
            @(posedge sample_clock);
            #1;
            n = n + 1;
        end while (!acc && n < 1000);
        check("accept", 32'(acc), 32'd1);
    endtask

    // Starts #1 after a frame-start edge; samples each bit while bclk is high
    task automatic capture(output logic [31:0] data, output logic [31:0] lr);
        data = '0;
        lr   = '0;
        for (int k = 0; k < 2 * DATA_W; k++) begin
            wait_cyc(CLK_DIV + 1);
            data = {data[30:0], dac_sdata};
            lr   = {lr[30:0], dac_lrclk};
            wait_cyc(CLK_DIV - 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic frame: A5C3 on both channels, lrclk period
        do_reset();
        send(16'hA5C3);
        in_valid = 1'b0;
        capture(frm, lrv);
        check("f0_data", frm, 32'hA5C3_A5C3);
        check("f0_lrclk", lrv, 32'h0000_FFFF);
        capture(frm, lrv);
        check("f1_data", frm, 32'hA5C3_A5C3);
        check("f1_lrclk", lrv, 32'h0000_FFFF);
        check("lr_period", 32'(lr_period), 32'(FRAME_CYC));

        // Back-to-back samples: one accept per frame, in order, no underrun
        do_reset();
        ur0 = ur_count;
        send(16'h0001);
        fork
            begin
                send(16'h8000);
                send(16'h7FFF);
                in_valid = 1'b0;
            end
            begin
                capture(frm, lrv);
                check("seq_f0", frm, 32'h0001_0001);
                capture(frm, lrv);
                check("seq_f1", frm, 32'h8000_8000);
                capture(frm, lrv);
                check("seq_f2", frm, 32'h7FFF_7FFF);
            end
        join
        check("seq_no_underrun", 32'(ur_count - ur0), 32'd0);

        // Starvation: repeat the sample, one underrun pulse per frame start
        do_reset();
        ur0 = ur_count;
        send(16'h1234);
        in_valid = 1'b0;
        for (int f = 0; f < 3; f++) begin
            capture(frm, lrv);
            check("starve_frame", frm, 32'h1234_1234);
        end
        check("starve_ur2", 32'(ur_count - ur0), 32'd2);
        wait_cyc(1);
        check("starve_ur3", 32'(ur_count - ur0), 32'd3);

        // Accept coincident with an empty frame start
        do_reset();
        send(16'h1234);
        in_valid = 1'b0;
        wait_cyc(FRAME_CYC - 1);
        ur0          = ur_count;
        input_sample = 16'hBEEF;
        in_valid     = 1'b1;
        check("coin_ready", 32'(in_ready), 32'd1);
        wait_cyc(1);
        in_valid = 1'b0;
        check("coin_underrun", 32'(underrun), 32'd1);
        capture(frm, lrv);
        check("coin_f1", frm, 32'h1234_1234);
        capture(frm, lrv);
        check("coin_f2", frm, 32'hBEEF_BEEF);
        check("coin_ur_cnt", 32'(ur_count - ur0), 32'd1);

        // Reset in the middle of bit 10 (bclk high, data bit 1)
        do_reset();
        send(16'h0020);
        in_valid = 1'b0;
        wait_cyc(10 * 2 * CLK_DIV + CLK_DIV + 1);
        check("pre_reset", 32'({dac_bclk, dac_lrclk, dac_sdata}), 32'b101);
        reset = 1'b1;
        wait_cyc(1);
        check("mid_reset", pins(), 32'b00001);
        wait_cyc(2);
        check("mid_reset_hold", pins(), 32'b00001);
        reset = 1'b0;
        wait_cyc(1);
        send(16'h8001);
        in_valid = 1'b0;
        capture(frm, lrv);
        check("restart_data", frm, 32'h8001_8001);
        check("restart_lrclk", lrv, 32'h0000_FFFF);

`ifdef DAC_SERIALIZER_UNDERRUN_CNT_EN
        // Underrun counter: three starved frames, then saturation
        do_reset();
        check("cnt_reset", 32'(underrun_count), 32'd0);
        send(16'h0F0F);
        in_valid = 1'b0;
        wait_cyc(3 * FRAME_CYC + 1);
        check("cnt_three", 32'(underrun_count), 32'd3);
        force dut.underrun_count = 16'hFFFE;
        wait_cyc(1);
        release dut.underrun_count;
        wait_cyc(2 * FRAME_CYC);
        check("cnt_saturate", 32'(underrun_count), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sample_clock cycles per half bit-clock period; legal range 2..255.
REQ-002 SHALL have parameter DATA_W, default 16: sample width in bits.
REQ-003 SHALL have port sample_clock, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port input_sample, input, DATA_W: two's-complement sample from the DSP stage output.
REQ-006 SHALL have port in_valid, input, 1: input_sample is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: the holding register is empty; a sample is accepted when in_valid && in_ready.
REQ-008 SHALL have port dac_bclk, output, 1: serial bit clock to the DAC.
REQ-009 SHALL have port dac_lrclk, output, 1: channel select; 0 = left, 1 = right.
REQ-010 SHALL have port dac_sdata, output, 1: serial data, MSB first, left-justified.
REQ-011 SHALL have port underrun, output, 1: one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-012 SHALL implement state IDLE (after reset) and state RUN; IDLE -> RUN on the first accepted sample; there is no return to IDLE except by reset.
REQ-013 In IDLE, SHALL hold in_ready=1 and keep dac_bclk, dac_lrclk and dac_sdata at 0.
REQ-014 On entering RUN (the cycle after the first accept), SHALL load the shifter with that sample, set div_cnt=0, bit index=0, dac_lrclk=0 and dac_sdata=bit DATA_W-1; the holding register stays empty.
REQ-015 In RUN, SHALL toggle dac_bclk when div_cnt reaches CLK_DIV-1; div_cnt then wraps to 0.
REQ-016 SHALL change dac_sdata and dac_lrclk only on bclk falling events (the toggle from 1 to 0); the DAC samples on rising edges.
REQ-017 Each frame SHALL be 2*DATA_W bit periods: bit index 0..DATA_W-1 is left (lrclk=0), DATA_W..2*DATA_W-1 is right (lrclk=1); one frame = 4*DATA_W*CLK_DIV cycles.
REQ-018 SHALL send the same sample on both channels (mono duplication), MSB first per channel.
REQ-019 At the falling event that wraps the bit index from 2*DATA_W-1 to 0 (frame start), SHALL load the shifter from the holding register and mark the holding register empty.
REQ-020 If the holding register is empty at frame start, SHALL reload the previous sample and pulse underrun for exactly that cycle.
REQ-021 SHALL drive in_ready=1 in RUN only while the holding register is empty; at most one sample is accepted per frame.
REQ-022 If an accept and a frame start fall in the same cycle with the holding register empty, SHALL count it as an underrun; the accepted sample goes to the holding register for the next frame (no bypass).
REQ-023 Input-to-pin latency: a sample accepted in frame N SHALL appear in frame N+1.

Reset
REQ-024 reset SHALL return the block to IDLE with in_ready=1, dac_bclk=0, dac_lrclk=0, dac_sdata=0, underrun=0, holding register empty, shifter, previous sample and counters cleared.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no partial bits are emitted after reset.

Configuration
REQ-026 With DAC_SERIALIZER_UNDERRUN_CNT_EN defined, SHALL add output underrun_count[15:0]: it increments on each underrun pulse, saturates at 16'hFFFF and is cleared by reset.
REQ-027 Without DAC_SERIALIZER_UNDERRUN_CNT_EN, the underrun_count port and counter SHALL NOT exist; all other behaviour is unchanged.

Structure
REQ-028 A shared package dsp_pkg SHALL hold the state enum (IDLE, RUN), the DATA_W default and the CLK_DIV default.
REQ-029 A sub-module bclk_divider (div counter, bclk register, rise/fall event strobes) SHALL be instantiated once; shifter, holding register and FSM stay in the top module.

Verification
REQ-030 Reset, then accept 16'hA5C3 (CLK_DIV=4) -> dac_sdata carries 1010010111000011 on left then right; lrclk period is 256 cycles.
REQ-031 Hold in_valid=1 with 16'h0001, 16'h8000, 16'h7FFF -> one accept per frame; frames carry the samples in order; underrun never pulses.
REQ-032 Accept 16'h1234, then no further input -> underrun pulses once per frame start; every frame repeats 16'h1234.
REQ-033 Assert in_valid exactly in the frame-start cycle with the holding register empty -> underrun=1; the sample is sent in the following frame.
REQ-034 Assert reset at bit index 10 -> the next cycle shows all outputs 0, IDLE, in_ready=1; a new accept restarts the frame at bit 0.
REQ-035 With DAC_SERIALIZER_UNDERRUN_CNT_EN, starve 3 frames -> underrun_count=3; force the counter near 16'hFFFF -> it stays at 16'hFFFF.
